// File: rtl/lgdst_ts_deframer.sv
// Serial MPEG-TS deframer: synchronises ITE9317 serial TS, locks on the 0x47 sync byte, emits byte-wide packets.
// Latency: byte N>=3 valid at S+1 of its last-bit strobe S; header bytes 0..2 burst at S+1..S+3 of byte 2's last strobe.
// Backpressure: none; the output is a pulse stream and downstream must take every pkt_valid.
// Build option: define TS_NULL_DROP_EN to drop PID 0x1FFF null packets from the output.
module lgdst_ts_deframer #(
    parameter int LOCK_GOOD = 3,
    parameter int LOCK_MISS = 3
) (
    input  logic        clk,
    input  logic        resync_n,
    input  logic        ts_clk,
    input  logic        ts_d0,
    input  logic        ts_valid,
    input  logic        ts_sync,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        pkt_abort,
    output logic        lock,
    output logic [7:0]  sync_err_cnt,
    output logic [15:0] pkt_cnt
);

    localparam logic [7:0] SYNC_BYTE   = 8'h47;
    localparam logic [7:0] LAST_BYTE   = 8'd187;
    localparam logic [7:0] LOCK_GOOD_W = 8'(LOCK_GOOD);
    localparam logic [7:0] LOCK_MISS_W = 8'(LOCK_MISS);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic [1:0] clk_s;
    logic [1:0] d_s;
    logic [1:0] v_s;
    logic [1:0] y_s;
    logic       clk_prev;
    logic       strobe;
    logic       bit_d;
    logic       bit_y;

    // Two-stage synchronisers on every TS pin plus the ts_clk edge register.
    always_ff @(posedge clk) begin
        if (!resync_n) begin
            clk_s    <= 2'b00;
            d_s      <= 2'b00;
            v_s      <= 2'b00;
            y_s      <= 2'b00;
            clk_prev <= 1'b0;
        end else begin
            clk_s    <= {clk_s[0], ts_clk};
            d_s      <= {d_s[0], ts_d0};
            v_s      <= {v_s[0], ts_valid};
            y_s      <= {y_s[0], ts_sync};
            clk_prev <= clk_s[1];
        end
    end

    // A bit is taken on a synchronised ts_clk rise only while ts_valid is high;
    // ts_sync rides with the same qualifier, so sync on an invalid bit is ignored.
    assign strobe = clk_s[1] & ~clk_prev & v_s[1];
    assign bit_d  = d_s[1];
    assign bit_y  = y_s[1];

    // ------------------------------------------------------------------
    // Bit / byte counters and byte assembly
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [2:0] eff_bit;
    logic [7:0] eff_byte;
    logic [7:0] shift_reg;
    logic       start_sync;
    logic       done_q;
    logic [7:0] done_byte;
    logic [7:0] done_idx;
    logic       done_sync;
    logic       realign_q;

    // A sync-marked bit restarts the packet at bit 0 of byte 0.
    always_comb begin
        eff_bit  = bit_y ? 3'd0 : bit_cnt;
        eff_byte = bit_y ? 8'd0 : byte_cnt;
    end

    // Shift bits MSB first, publish each completed byte for one cycle,
    // and flag a sync that lands anywhere other than the expected packet start.
    always_ff @(posedge clk) begin
        if (!resync_n) begin
            bit_cnt    <= 3'd0;
            byte_cnt   <= 8'd0;
            shift_reg  <= 8'h00;
            start_sync <= 1'b0;
            done_q     <= 1'b0;
            done_byte  <= 8'h00;
            done_idx   <= 8'd0;
            done_sync  <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            realign_q <= 1'b0;
            if (strobe) begin
                shift_reg <= {shift_reg[6:0], bit_d};
                realign_q <= bit_y && ((bit_cnt != 3'd0) || (byte_cnt != 8'd0));
                if (eff_bit == 3'd0) begin
                    start_sync <= bit_y;
                end
                if (eff_bit == 3'd7) begin
                    bit_cnt   <= 3'd0;
                    byte_cnt  <= (eff_byte == LAST_BYTE) ? 8'd0 : eff_byte + 8'd1;
                    done_q    <= 1'b1;
                    done_byte <= {shift_reg[6:0], bit_d};
                    done_idx  <= eff_byte;
                    done_sync <= start_sync;
                end else begin
                    bit_cnt  <= eff_bit + 3'd1;
                    byte_cnt <= eff_byte;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock state machine, evaluated when byte 0 completes
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [7:0] good_cnt;
    logic [7:0] good_nxt;
    logic [7:0] miss_cnt;
    logic [7:0] miss_nxt;
    logic       eval;
    logic       sync_ok;
    logic       accept;
    logic       sync_bad;

    assign eval    = done_q && (done_idx == 8'd0);
    assign sync_ok = (done_byte == SYNC_BYTE);

    // State register for the lock tracker.
    always_ff @(posedge clk) begin
        if (!resync_n) begin
            state    <= ST_HUNT;
            good_cnt <= 8'd0;
            miss_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    // Next-state: HUNT needs a sync-started 0x47, VERIFY counts good syncs,
    // LOCKED counts misses and decides whether this packet may be emitted.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        miss_nxt  = miss_cnt;
        accept    = 1'b0;
        sync_bad  = 1'b0;
        if (eval) begin
            case (state)
                ST_HUNT: begin
                    if (sync_ok && done_sync) begin
                        good_nxt  = 8'd1;
                        miss_nxt  = 8'd0;
                        state_nxt = (LOCK_GOOD_W <= 8'd1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (sync_ok) begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 >= LOCK_GOOD_W) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = 8'd0;
                        end
                    end else begin
                        good_nxt  = 8'd0;
                        state_nxt = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (sync_ok) begin
                        miss_nxt = 8'd0;
                        accept   = 1'b1;
                    end else begin
                        sync_bad = 1'b1;
                        miss_nxt = miss_cnt + 8'd1;
                        if (miss_cnt + 8'd1 >= LOCK_MISS_W) begin
                            state_nxt = ST_HUNT;
                            good_nxt  = 8'd0;
                            miss_nxt  = 8'd0;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                    good_nxt  = 8'd0;
                    miss_nxt  = 8'd0;
                end
            endcase
        end
    end

    assign lock = (state == ST_LOCKED);

    // ------------------------------------------------------------------
    // Packet emission
    // ------------------------------------------------------------------
    logic       pkt_active;   // packet accepted at byte 0, still owed output
    logic       pkt_open;     // sop already emitted, eop/abort still owed
    logic [7:0] hdr0;
    logic [7:0] hdr1;
    logic [7:0] hdr2;
    logic [1:0] burst_left;
    logic       is_null;

`ifdef TS_NULL_DROP_EN
    assign is_null = ({hdr1[4:0], done_byte} == 13'h1FFF);
`else
    assign is_null = 1'b0;
`endif

    // Hold the 3-byte header until the PID is known, then burst it out;
    // stream bytes 3..187 as they complete; abort an open packet on realign.
    always_ff @(posedge clk) begin
        if (!resync_n) begin
            pkt_data     <= 8'h00;
            pkt_valid    <= 1'b0;
            pkt_sop      <= 1'b0;
            pkt_eop      <= 1'b0;
            pkt_abort    <= 1'b0;
            sync_err_cnt <= 8'd0;
            pkt_cnt      <= 16'd0;
            pkt_active   <= 1'b0;
            pkt_open     <= 1'b0;
            hdr0         <= 8'h00;
            hdr1         <= 8'h00;
            hdr2         <= 8'h00;
            burst_left   <= 2'd0;
        end else begin
            pkt_valid <= 1'b0;
            pkt_sop   <= 1'b0;
            pkt_eop   <= 1'b0;
            pkt_abort <= 1'b0;

            if (sync_bad && (sync_err_cnt != 8'hFF)) begin
                sync_err_cnt <= sync_err_cnt + 8'd1;
            end

            if (burst_left == 2'd2) begin
                pkt_valid  <= 1'b1;
                pkt_data   <= hdr1;
                burst_left <= 2'd1;
            end else if (burst_left == 2'd1) begin
                pkt_valid  <= 1'b1;
                pkt_data   <= hdr2;
                burst_left <= 2'd0;
            end

            if (realign_q) begin
                // A new packet starts here; whatever was in flight is abandoned.
                pkt_active <= 1'b0;
                if (pkt_open) begin
                    pkt_abort <= 1'b1;
                    pkt_open  <= 1'b0;
                end
            end else if (done_q) begin
                if (done_idx == 8'd0) begin
                    hdr0       <= done_byte;
                    pkt_active <= accept;
                end else if (done_idx == 8'd1) begin
                    hdr1 <= done_byte;
                end else if (done_idx == 8'd2) begin
                    hdr2 <= done_byte;
                    if (pkt_active && !is_null) begin
                        pkt_valid  <= 1'b1;
                        pkt_sop    <= 1'b1;
                        pkt_data   <= hdr0;
                        burst_left <= 2'd2;
                        pkt_open   <= 1'b1;
                    end else begin
                        pkt_active <= 1'b0;
                    end
                end else if (pkt_active) begin
                    pkt_valid <= 1'b1;
                    pkt_data  <= done_byte;
                    if (done_idx == LAST_BYTE) begin
                        pkt_eop    <= 1'b1;
                        pkt_cnt    <= pkt_cnt + 16'd1;
                        pkt_active <= 1'b0;
                        pkt_open   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lgdst_ts_deframer.sv
// Directed bench for lgdst_ts_deframer: serial TS at clk/4, byte capture on negedge.
`timescale 1ns/1ps
module tb_lgdst_ts_deframer;

    logic        clk      = 1'b0;
    logic        resync_n = 1'b0;
    logic        ts_clk   = 1'b0;
    logic        ts_d0    = 1'b0;
    logic        ts_valid = 1'b0;
    logic        ts_sync  = 1'b0;
    logic [7:0]  pkt_data;
    logic        pkt_valid;
    logic        pkt_sop;
    logic        pkt_eop;
    logic        pkt_abort;
    logic        lock;
    logic [7:0]  sync_err_cnt;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    lgdst_ts_deframer dut (
        .clk          (clk),
        .resync_n     (resync_n),
        .ts_clk       (ts_clk),
        .ts_d0        (ts_d0),
        .ts_valid     (ts_valid),
        .ts_sync      (ts_sync),
        .pkt_data     (pkt_data),
        .pkt_valid    (pkt_valid),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_abort    (pkt_abort),
        .lock         (lock),
        .sync_err_cnt (sync_err_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled away from the active edge.
    int         n_valid   = 0;
    int         n_sop     = 0;
    int         n_eop     = 0;
    int         n_abort   = 0;
    int         pos       = 0;
    int         eop_pos   = -1;
    int         abort_pos = -1;
    logic [7:0] cur      [188];
    logic [7:0] last_pkt [188];

    always @(negedge clk) begin
        if (pkt_valid) begin
            if (pkt_sop) begin
                n_sop++;
                pos = 0;
            end
            if (pos < 188) cur[pos] = pkt_data;
            if (pkt_eop) begin
                n_eop++;
                eop_pos  = pos;
                last_pkt = cur;
            end
            pos++;
            n_valid++;
        end
        if (pkt_abort) begin
            n_abort++;
            abort_pos = pos;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] b0, input logic [12:0] pid,
                                            input int seed, input int idx);
        if (idx == 0) return b0;
        if (idx == 1) return {3'b000, pid[12:8]};
        if (idx == 2) return pid[7:0];
        return 8'((seed * 7 + idx * 13) & 255);
    endfunction

    // One TS bit: ts_clk low for 2 clk, high for 2 clk (clk = 4x ts_clk).
    task automatic send_bit(input logic d, input logic s, input logic v);
        ts_clk   = 1'b0;
        ts_d0    = d;
        ts_sync  = s;
        ts_valid = v;
        repeat (2) @(negedge clk);
        ts_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // nbytes < 188 sends bytes 0..nbytes-1 then only 3 bits of byte nbytes.
    // gap_at >= 0 inserts 13 invalid bit periods after bit 4 of that byte.
    task automatic send_packet(input logic [7:0] b0, input logic [12:0] pid, input int seed,
                               input int nbytes, input int gap_at);
        logic [7:0] b;
        int lim;
        int lo;
        lim = (nbytes < 188) ? nbytes : 187;
        for (int k = 0; k <= lim; k++) begin
            b  = exp_byte(b0, pid, seed, k);
            lo = (k == nbytes) ? 5 : 0;
            for (int i = 7; i >= lo; i--) begin
                send_bit(b[i], (k == 0) && (i == 7), 1'b1);
                if ((k == gap_at) && (i == 4)) begin
                    for (int j = 0; j < 13; j++) send_bit(j[0], (j == 5), 1'b0);
                end
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_last_pkt(input string tag, input logic [7:0] b0, input logic [12:0] pid,
                                  input int seed);
        int bad;
        bad = 0;
        for (int k = 0; k < 188; k++) begin
            if (last_pkt[k] !== exp_byte(b0, pid, seed, k)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    int snap_valid;
    int snap_sop;
    int snap_eop;
    int snap_abort;
    int snap_cnt;
    int exp_null;

    initial begin
        // Reset
        repeat (4) @(negedge clk);
        check("rst_lock",    32'(lock),         32'd0);
        check("rst_valid",   32'(pkt_valid),    32'd0);
        check("rst_data",    32'(pkt_data),     32'd0);
        check("rst_abort",   32'(pkt_abort),    32'd0);
        check("rst_err_cnt", 32'(sync_err_cnt), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt),      32'd0);
        resync_n = 1'b1;
        repeat (4) @(negedge clk);

        // Acquisition: lock after the 3rd sync byte, packets 4 and 5 emitted
        send_packet(8'h47, 13'h0100, 1, 188, -1);
        check("acq_p1_lock", 32'(lock), 32'd0);
        send_packet(8'h47, 13'h0100, 2, 188, -1);
        check("acq_p2_lock", 32'(lock), 32'd0);
        send_packet(8'h47, 13'h0100, 3, 188, -1);
        check("acq_p3_lock",  32'(lock), 32'd1);
        check("acq_p3_quiet", 32'(n_valid), 32'd0);
        send_packet(8'h47, 13'h0100, 4, 188, -1);
        send_packet(8'h47, 13'h0100, 5, 188, -1);
        check("acq_pkt_cnt", 32'(pkt_cnt), 32'd2);
        check("acq_sops",    32'(n_sop),   32'd2);
        check("acq_eops",    32'(n_eop),   32'd2);
        check("acq_bytes",   32'(n_valid), 32'd376);
        check("acq_eop_pos", 32'(eop_pos), 32'd187);
        check("acq_sop_byte", 32'(last_pkt[0]), 32'h47);
        check_last_pkt("acq_p5_content", 8'h47, 13'h0100, 5);

        // Realign mid-packet: abort after 50 emitted bytes; next packet (with a
        // 13-bit ts_valid gap at byte 100) emitted intact
        send_packet(8'h47, 13'h0100, 9, 50, -1);
        send_packet(8'h47, 13'h0100, 11, 188, 100);
        check("abort_count",   32'(n_abort),   32'd1);
        check("abort_pos",     32'(abort_pos), 32'd50);
        check("abort_sops",    32'(n_sop),     32'd4);
        check("abort_eops",    32'(n_eop),     32'd3);
        check("abort_pkt_cnt", 32'(pkt_cnt),   32'd3);
        check("abort_lock",    32'(lock),      32'd1);
        check_last_pkt("gap_content", 8'h47, 13'h0100, 11);

        // Null PID between two ordinary packets
`ifdef TS_NULL_DROP_EN
        exp_null = 2;
`else
        exp_null = 3;
`endif
        snap_cnt = int'(pkt_cnt);
        snap_sop = n_sop;
        send_packet(8'h47, 13'h0100, 21, 188, -1);
        send_packet(8'h47, 13'h1FFF, 22, 188, -1);
        send_packet(8'h47, 13'h0100, 23, 188, -1);
        check("null_pkt_cnt", 32'(int'(pkt_cnt) - snap_cnt), 32'(exp_null));
        check("null_sops",    32'(n_sop - snap_sop),        32'(exp_null));
        check_last_pkt("null_last_content", 8'h47, 13'h0100, 23);

        // resync_n pulse at byte 100 of an emitting packet
        send_packet(8'h47, 13'h0100, 31, 100, -1);
        snap_eop   = n_eop;
        snap_abort = n_abort;
        ts_valid   = 1'b0;
        resync_n   = 1'b0;
        @(negedge clk);
        resync_n = 1'b1;
        check("rsy_lock",    32'(lock),         32'd0);
        check("rsy_valid",   32'(pkt_valid),    32'd0);
        check("rsy_data",    32'(pkt_data),     32'd0);
        check("rsy_pkt_cnt", 32'(pkt_cnt),      32'd0);
        check("rsy_err_cnt", 32'(sync_err_cnt), 32'd0);
        repeat (4) @(negedge clk);
        send_packet(8'h47, 13'h0100, 41, 8, -1);
        send_packet(8'h47, 13'h0100, 42, 8, -1);
        check("rsy_p2_lock", 32'(lock), 32'd0);
        send_packet(8'h47, 13'h0100, 43, 8, -1);
        check("rsy_p3_lock",  32'(lock),    32'd1);
        check("rsy_no_eop",   32'(n_eop),   32'(snap_eop));
        check("rsy_no_abort", 32'(n_abort), 32'(snap_abort));

        // Bad sync bytes while locked
        snap_valid = n_valid;
        send_packet(8'h00, 13'h0100, 51, 8, -1);
        check("bad1_lock", 32'(lock),         32'd1);
        check("bad1_err",  32'(sync_err_cnt), 32'd1);
        check("bad1_quiet", 32'(n_valid),     32'(snap_valid));
        send_packet(8'h00, 13'h0100, 52, 8, -1);
        check("bad2_lock", 32'(lock),         32'd1);
        check("bad2_err",  32'(sync_err_cnt), 32'd2);
        send_packet(8'h00, 13'h0100, 53, 8, -1);
        check("bad3_lock", 32'(lock),         32'd0);
        check("bad3_err",  32'(sync_err_cnt), 32'd3);
        check("bad_quiet", 32'(n_valid),      32'(snap_valid));
        check("bad_no_abort", 32'(n_abort),   32'(snap_abort));
        check("bad_pkt_cnt",  32'(pkt_cnt),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
